// File: rtl/quad_sampler_if.sv
// Record stream from the sampler to the host-side consumer (valid/ready).
interface quad_sampler_if #(
  parameter int unsigned CH_W = 2
);
  logic            out_valid;
  logic            out_ready;
  logic [CH_W-1:0] out_channel;
  logic [23:0]     out_position;
  logic [15:0]     out_velocity;
  logic [7:0]      out_sample_id;

  modport master (
    output out_valid,
    input  out_ready,
    output out_channel,
    output out_position,
    output out_velocity,
    output out_sample_id
  );

  modport slave (
    input  out_valid,
    output out_ready,
    input  out_channel,
    input  out_position,
    input  out_velocity,
    input  out_sample_id
  );
endinterface

// File: rtl/quad_sampler.sv
// Periodic snapshot of all encoder counts, then one {channel, position, velocity}
// record per channel through a shared delta/saturation datapath.
module quad_sampler #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CLK_FREQ_HZ = 32_000_000,
  parameter int unsigned SAMPLE_HZ   = 1000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [24*NUM_CH-1:0]   counts_i,
  input  logic                   clear_overrun,
  output logic                   overrun,
  quad_sampler_if.master         bus
);
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned PERIOD = CLK_FREQ_HZ / SAMPLE_HZ;
  localparam int unsigned TC_W   = $clog2(PERIOD);
  localparam logic [TC_W-1:0] TC_LAST  = TC_W'(PERIOD - 1);
  localparam logic [CH_W-1:0] IDX_LAST = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StEmit} state_e;

  state_e          state_q, state_d;
  logic [TC_W-1:0] tc_q;
  logic            tick;
  logic [CH_W-1:0] idx_q;
  logic [23:0]     snap_q [NUM_CH];
  logic [23:0]     prev_q [NUM_CH];
  logic            primed_q;
  logic [7:0]      sample_id_q;
  logic [CH_W-1:0] out_channel_q;
  logic [23:0]     out_position_q;
  logic [15:0]     out_velocity_q;
  logic            overrun_q;

  logic [23:0] snap_sel, prev_sel, delta;
  logic [15:0] vel_sat;
  logic        snap_en, load_en, accept;

  assign tick = (tc_q == TC_LAST);

  // Free-running sample tick counter; held at zero while disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tc_q <= '0;
    end else if (!enable || tick) begin
      tc_q <= '0;
    end else begin
      tc_q <= tc_q + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath strobes.
  always_comb begin
    state_d = state_q;
    snap_en = 1'b0;
    load_en = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (tick) begin
          snap_en = 1'b1;
          state_d = StLoad;
        end
      end
      StLoad: begin
        load_en = 1'b1;
        state_d = StEmit;
      end
      StEmit: begin
        if (bus.out_ready) begin
          accept  = 1'b1;
          state_d = (idx_q == IDX_LAST) ? StIdle : StLoad;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Modular 24-bit delta, clamped to the signed 16-bit range.
  always_comb begin
    snap_sel = snap_q[idx_q];
    prev_sel = prev_q[idx_q];
    delta    = snap_sel - prev_sel;
    // In range only when bits [23:15] are a pure sign extension.
    if (!delta[23] && (delta[22:15] != 8'h00)) begin
      vel_sat = 16'h7FFF;
    end else if (delta[23] && (delta[22:15] != 8'hFF)) begin
      vel_sat = 16'h8000;
    end else begin
      vel_sat = delta[15:0];
    end
  end

  // Snapshot, per-channel record load and history update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_CH; k++) begin
        snap_q[k] <= '0;
        prev_q[k] <= '0;
      end
      idx_q          <= '0;
      primed_q       <= 1'b0;
      sample_id_q    <= '0;
      out_channel_q  <= '0;
      out_position_q <= '0;
      out_velocity_q <= '0;
    end else begin
      if (snap_en) begin
        for (int k = 0; k < NUM_CH; k++) begin
          snap_q[k] <= counts_i[24*k +: 24];
        end
        idx_q       <= '0;
        sample_id_q <= sample_id_q + 8'd1;
      end
      if (load_en) begin
        out_position_q <= snap_sel;
        out_channel_q  <= idx_q;
        out_velocity_q <= primed_q ? vel_sat : 16'd0;
      end
      if (accept) begin
        prev_q[idx_q] <= snap_sel;
        if (idx_q == IDX_LAST) begin
          primed_q <= 1'b1;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
    end
  end

  // Sticky drop flag; a drop in the same cycle as a clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_q <= 1'b0;
    end else if (tick && (state_q != StIdle)) begin
      overrun_q <= 1'b1;
    end else if (clear_overrun) begin
      overrun_q <= 1'b0;
    end
  end

  assign bus.out_valid     = (state_q == StEmit);
  assign bus.out_channel   = out_channel_q;
  assign bus.out_position  = out_position_q;
  assign bus.out_velocity  = out_velocity_q;
  assign bus.out_sample_id = sample_id_q;
  assign overrun           = overrun_q;

endmodule

// File: tb/tb_quad_sampler.sv
// Directed bench for quad_sampler with a record scoreboard.
module tb_quad_sampler;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CH_W   = 2;

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic [23:0]     pos;
    logic [15:0]     vel;
    logic [7:0]      sid;
  } rec_t;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 enable;
  logic [24*NUM_CH-1:0] counts;
  logic                 clear_overrun;
  logic                 overrun;

  quad_sampler_if #(.CH_W(CH_W)) bus ();

  quad_sampler #(
    .NUM_CH     (NUM_CH),
    .CLK_FREQ_HZ(1000),
    .SAMPLE_HZ  (100)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .counts_i     (counts),
    .clear_overrun(clear_overrun),
    .overrun      (overrun),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  rec_t        sb[$];
  logic [23:0] m_prev [NUM_CH];
  bit          m_primed;
  logic [7:0]  m_sid;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NUM_CH; k++) m_prev[k] = '0;
    m_primed = 1'b0;
    m_sid    = '0;
  endtask

  // Drive a new set of counts and queue the records the next batch must produce.
  task automatic set_batch(input logic [23:0] c0, input logic [23:0] c1,
                           input logic [23:0] c2, input logic [23:0] c3);
    logic [23:0] c [NUM_CH];
    logic [23:0] diff;
    int          d;
    rec_t        r;
    c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
    counts = {c3, c2, c1, c0};
    m_sid  = m_sid + 8'd1;
    for (int k = 0; k < NUM_CH; k++) begin
      diff = c[k] - m_prev[k];
      d = int'(diff);
      if (d >= 8388608) d = d - 16777216;
      if (d > 32767) d = 32767;
      else if (d < -32768) d = -32768;
      r.ch  = CH_W'(k);
      r.pos = c[k];
      r.vel = m_primed ? 16'(d) : 16'd0;
      r.sid = m_sid;
      sb.push_back(r);
      m_prev[k] = c[k];
    end
    m_primed = 1'b1;
  endtask

  // From a falling edge, count rising edges until out_valid is seen (bounded).
  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
  endtask

  task automatic collect(input int num);
    int   n;
    rec_t obs;
    for (int i = 0; i < num; i++) begin
      wait_valid(n);
      check("rec_valid", 64'(bus.out_valid), 64'd1);
      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        obs = {bus.out_channel, bus.out_position, bus.out_velocity, bus.out_sample_id};
        check("record", 64'(obs), 64'(sb.pop_front()));
      end
      @(posedge clk);
      @(negedge clk);
      check("valid_gap", 64'(bus.out_valid), 64'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    rec_t obs;
    reset         = 1'b1;
    enable        = 1'b0;
    counts        = '0;
    clear_overrun = 1'b0;
    bus.out_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);

    check("rst_valid",    64'(bus.out_valid),     64'd0);
    check("rst_channel",  64'(bus.out_channel),   64'd0);
    check("rst_position", 64'(bus.out_position),  64'd0);
    check("rst_velocity", 64'(bus.out_velocity),  64'd0);
    check("rst_sid",      64'(bus.out_sample_id), 64'd0);
    check("rst_overrun",  64'(overrun),           64'd0);

    // First batch: unprimed, zero velocity; 10 edges to snapshot plus one LOAD.
    bus.out_ready = 1'b1;
    set_batch(24'd100, 24'd200, 24'd300, 24'd400);
    reset  = 1'b0;
    enable = 1'b1;
    wait_valid(n);
    check("latency_first", 64'(n), 64'd11);
    collect(4);

    set_batch(24'd110, 24'd190, 24'd300, 24'h000400);
    collect(4);

    // Wrap and saturation.
    set_batch(24'hFFFFFE, 24'h0, 24'h0, 24'h0);
    collect(4);
    set_batch(24'h000001, 24'h010000, 24'hFF0000, 24'h0);
    collect(4);
    check("sb_drained", 64'(sb.size()), 64'd0);

    // Backpressure on ch1 across a tick.
    set_batch(24'd5, 24'd6, 24'd7, 24'd8);
    collect(1);
    wait_valid(n);
    bus.out_ready = 1'b0;
    repeat (15) begin
      obs = {bus.out_channel, bus.out_position, bus.out_velocity, bus.out_sample_id};
      check("bp_hold", 64'({bus.out_valid, obs}), 64'({1'b1, sb[0]}));
      @(posedge clk);
      @(negedge clk);
    end
    check("overrun_set", 64'(overrun), 64'd1);
    bus.out_ready = 1'b1;
    collect(3);
    clear_overrun = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear_overrun = 1'b0;
    check("overrun_clear", 64'(overrun), 64'd0);
    set_batch(24'd9, 24'd9, 24'd9, 24'd9);
    collect(4);

    // Asynchronous reset while ch2 is being offered.
    set_batch(24'd20, 24'd30, 24'd40, 24'd50);
    collect(2);
    bus.out_ready = 1'b0;
    wait_valid(n);
    check("ch2_valid", 64'(bus.out_valid), 64'd1);
    #1 reset = 1'b1;
    #1;
    check("async_valid", 64'(bus.out_valid),     64'd0);
    check("async_sid",   64'(bus.out_sample_id), 64'd0);
    sb.delete();
    model_reset();
    @(negedge clk);
    reset         = 1'b0;
    bus.out_ready = 1'b1;
    set_batch(24'd1000, 24'd2000, 24'd3000, 24'd4000);
    wait_valid(n);
    check("latency_post_rst", 64'(n), 64'd11);
    collect(4);

    // Disabled: no batches.
    enable = 1'b0;
    repeat (30) begin
      @(posedge clk);
      @(negedge clk);
      check("disabled_idle", 64'(bus.out_valid), 64'd0);
    end
    enable = 1'b1;
    set_batch(24'd51000, 24'd1995, 24'd3000, 24'd4000);
    wait_valid(n);
    check("latency_enable", 64'(n), 64'd11);
    collect(4);
    check("sb_final", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/quad_sampler.md
# quad_sampler

Periodic sampling scheduler for the motor board's quadrature decoder counters. On every sample tick it snapshots the 24-bit position counts of all encoder channels at once. It then walks the channels in order through a single shared delta/saturation datapath and streams {channel, position, velocity} records to the downstream consumer (SPI/register bank) over a valid/ready handshake. It sits between the per-channel quadrature decoders and the host interface, and flags ticks it had to drop.

## Interface
- NUM_CH, 4, number of encoder channels (1..16)
- CLK_FREQ_HZ, 32_000_000, system clock frequency
- SAMPLE_HZ, 1000, sample rate; PERIOD = CLK_FREQ_HZ/SAMPLE_HZ cycles (integer, ≥ 4·NUM_CH+2)
- CH_W, derived: max(1, clog2(NUM_CH))

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- enable  in  1  tick generator run; low holds tick counter at 0
- counts_i  in  24·NUM_CH  channel k count at bits [24k+23:24k], from decoder outputs
- out_valid  out  1  record available
- out_ready  in  1  consumer accepts record
- out_channel  out  CH_W  channel index of record
- out_position  out  24  snapshotted count
- out_velocity  out  16  signed counts per sample period, saturated
- out_sample_id  out  8  batch number, identical for all records of one batch
- overrun  out  1  sticky: a tick arrived while a batch was in flight
- clear_overrun  in  1  synchronous clear of overrun

## Operation
- Tick counter tc counts 0..PERIOD-1 while enable=1, wraps; tick is high in the cycle tc==PERIOD-1. enable=0 forces tc=0 next edge; a batch already in flight still completes.
- FSM states: IDLE, LOAD, EMIT.
  - IDLE: on an edge with tick=1, snap[k] <= counts_i[k] for all k; idx <= 0; sample_id <= sample_id+1 (8-bit wrap); go to LOAD.
  - LOAD: one cycle. Register out_position <= snap[idx], out_channel <= idx, out_velocity <= sat16(snap[idx]-prev[idx]) (or 0 if not primed); go to EMIT.
  - EMIT: out_valid=1. On an edge with out_ready=1: prev[idx] <= snap[idx]. If idx==NUM_CH-1, set primed <= 1 and go to IDLE; otherwise idx <= idx+1 and go to LOAD.
- Delta arithmetic: d = (snap − prev) mod 2^24, interpreted as signed 24-bit. Result is d clamped to [−32768, +32767]. Counter wrap is handled implicitly (0xFFFFFE→0x000001 gives +3).
- The first batch after reset has primed=0, so every velocity is 0. prev is loaded from that batch.
- A tick in LOAD or EMIT is dropped: no snapshot, and sample_id is not incremented. overrun is set on the next edge.
- clear_overrun clears overrun. If a dropped tick and clear_overrun occur in the same cycle, set wins.
- out_* fields are stable while out_valid=1 and out_ready=0. The consumer may hold out_ready low indefinitely.

## Timing
- Reset values: out_valid=0, out_channel=0, out_position=0, out_velocity=0, out_sample_id=0, overrun=0, tc=0, state=IDLE, primed=0, snap/prev=0.
- Reset is asynchronous at any point, including mid-batch. The partial batch is discarded, and the first batch afterwards reports zero velocity.
- Latency: snapshot edge E (tick=1, IDLE). LOAD occupies cycle E+1. out_valid is high from E+2 for channel 0.
- With out_ready held at 1, each channel takes 2 cycles (LOAD+EMIT). A batch takes 2·NUM_CH cycles after the snapshot edge, and out_valid toggles 1,0,1,0 between records.
- out_valid deasserts in the cycle after the final handshake. The next batch can start on any later tick.
- counts_i is sampled only at the snapshot edge; changes during a batch do not affect it.

## Test plan
- Bench parameters for all tests: CLK_FREQ_HZ=1000, SAMPLE_HZ=100 (PERIOD=10), NUM_CH=4.
- Reset then enable, counts={100,200,300,400}, out_ready=1 → first record at tick+2 cycles. Records arrive ch0..ch3 with positions 100..400, velocity 0, sample_id 1.
- Next batch with counts={110,190,300,0x000400} → velocities +10, −10, 0, +624. sample_id 2.
- Wrap and saturation: ch0 prev 0xFFFFFE → 0x000001 gives +3. ch1 prev 0 → 0x010000 gives +32767. ch2 prev 0 → 0xFF0000 gives −32768.
- Backpressure: hold out_ready=0 for 15 cycles during ch1. ch1 fields stay stable, the tick during that window is dropped, overrun=1, and the next batch's sample_id is only +1. Then pulse clear_overrun → overrun=0.
- Assert reset mid-EMIT for ch2 → out_valid=0 immediately (asynchronous). The next batch reports all velocities 0 and sample_id 1.
- enable=0 for 30 cycles → no batches and out_valid stays 0. After enable=1, the first tick occurs 10 cycles later.
